// File: rtl/baud_pkg.sv
// Shared baud generator definitions: standard rate table, FSM state type and default widths.
package baud_pkg;

    localparam int DIV_W_DEF      = 16;
    localparam int OVERSAMPLE_DEF = 16;
    localparam int RSEL_W_DEF     = 2;
    localparam int FRAC_W_DEF     = 4;

    // Divisors for 1200/2400/4800/9600 baud from a 50 MHz clock at 16x oversample.
    localparam int RATE_N = 4;
    localparam int unsigned RATE_TBL [RATE_N] = '{2604, 1302, 651, 326};

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    // Indices past the end of the table select the fastest standard rate.
    function automatic int unsigned rate_div(input int unsigned idx);
        int unsigned sel;
        sel = (idx >= RATE_N) ? RATE_N - 1 : idx;
        return RATE_TBL[sel[1:0]];
    endfunction

endpackage

// File: rtl/baud_tick_gen_if.sv
// Control and tick bundle between the UART engines (master) and the baud tick generator (slave).
interface baud_tick_gen_if #(
    parameter int DIV_W  = baud_pkg::DIV_W_DEF,
    parameter int RSEL_W = baud_pkg::RSEL_W_DEF,
    parameter int FRAC_W = baud_pkg::FRAC_W_DEF
);
    logic              en;
    logic [RSEL_W-1:0] rate_sel;
    logic              div_ovr;
    logic [DIV_W-1:0]  div_value;
    logic [FRAC_W-1:0] div_frac;
    logic              rx_tick;
    logic              tx_tick;
    logic              locked;

    modport master (
        output en, rate_sel, div_ovr, div_value, div_frac,
        input  rx_tick, tx_tick, locked
    );

    modport slave (
        input  en, rate_sel, div_ovr, div_value, div_frac,
        output rx_tick, tx_tick, locked
    );
endinterface

// File: rtl/baud_prescaler.sv
// Loadable down-counter with terminal-count flag; BAUD_FRAC_EN adds a fractional accumulator
// that stretches a reload by one cycle whenever the accumulator carries out.
module baud_prescaler #(
    parameter int DIV_W = 16
`ifdef BAUD_FRAC_EN
    , parameter int FRAC_W = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] load_val,
    input  logic [DIV_W-1:0] reload_div,
`ifdef BAUD_FRAC_EN
    input  logic [FRAC_W-1:0] frac,
`endif
    output logic             tc
);
    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] reload_val;

    assign tc = (count == '0);

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   acc_sum;

    assign acc_sum    = {1'b0, acc} + {1'b0, frac};
    assign reload_val = acc_sum[FRAC_W] ? reload_div : reload_div - DIV_W'(1);

    // The accumulator only advances on a terminal-count reload so the phase error stays bounded.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            acc <= '0;
        end else if (run && tc) begin
            acc <= acc_sum[FRAC_W-1:0];
        end
    end
`else
    assign reload_val = reload_div - DIV_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (run) begin
            count <= tc ? reload_val : count - DIV_W'(1);
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// Baud clock-enable generator: rx_tick every divisor clocks, tx_tick every OVERSAMPLE rx_ticks.
// Optional fractional divisor support is enabled by defining BAUD_FRAC_EN.
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int DIV_W      = DIV_W_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int RSEL_W     = RSEL_W_DEF,
    parameter int FRAC_W     = FRAC_W_DEF
) (
    input  logic clk,
    input  logic rst,
    baud_tick_gen_if.slave bus
);
    localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0] OS_MAX = OS_W'(OVERSAMPLE - 1);

    state_t            state;
    state_t            state_next;
    logic [RSEL_W-1:0] rate_idx;
    logic [DIV_W-1:0]  div_sel;
    logic [DIV_W-1:0]  div_eff;
    logic [DIV_W-1:0]  div_q;
    logic              div_change;
    logic              tc;
    logic              rx_hit;
    logic [OS_W-1:0]   os_cnt;

    assign rate_idx = bus.rate_sel;

    // A zero divisor would stall the prescaler, so it is promoted to one.
    always_comb begin
        div_sel = bus.div_ovr ? bus.div_value : DIV_W'(rate_div(32'(rate_idx)));
        div_eff = (div_sel == '0) ? DIV_W'(1) : div_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_eff;
        end
    end

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] frac_eff;
    logic [FRAC_W-1:0] frac_q;

    // Table rates are always integral; only the override carries a fraction.
    assign frac_eff = bus.div_ovr ? bus.div_frac : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            frac_q <= '0;
        end else begin
            frac_q <= frac_eff;
        end
    end

    assign div_change = (div_eff != div_q) || (frac_eff != frac_q);
`else
    logic [FRAC_W-1:0] unused_frac;

    assign unused_frac = bus.div_frac;
    assign div_change  = (div_eff != div_q);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Dropping en outranks a divisor change so a disable is never delayed by a reload.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.en) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = bus.en ? RUN : IDLE;
            end
            RUN: begin
                if (!bus.en) begin
                    state_next = IDLE;
                end else if (div_change) begin
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    baud_prescaler #(
        .DIV_W      (DIV_W)
`ifdef BAUD_FRAC_EN
        , .FRAC_W   (FRAC_W)
`endif
    ) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .load       (state == LOAD),
        .run        (state == RUN),
        .load_val   (div_eff - DIV_W'(1)),
        .reload_div (div_q),
`ifdef BAUD_FRAC_EN
        .frac       (frac_q),
`endif
        .tc         (tc)
    );

    assign rx_hit = (state == RUN) && tc;

    always_ff @(posedge clk) begin
        if (rst) begin
            os_cnt <= '0;
        end else if (state == LOAD) begin
            os_cnt <= OS_MAX;
        end else if (rx_hit) begin
            os_cnt <= (os_cnt == '0) ? OS_MAX : os_cnt - OS_W'(1);
        end
    end

    assign bus.rx_tick = rx_hit;
    assign bus.tx_tick = rx_hit && (os_cnt == '0);
    assign bus.locked  = (state == RUN);

endmodule

// File: tb/tb_baud_tick_gen.sv
// Self-checking bench for baud_tick_gen: directed steps plus random traffic against a tick-schedule model.
module tb_baud_tick_gen;
    localparam int DIV_W  = 16;
    localparam int OS     = 16;
    localparam int RSEL_W = 2;
    localparam int FRAC_W = 4;
    localparam int TBL [4] = '{2604, 1302, 651, 326};

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    baud_tick_gen_if #(.DIV_W(DIV_W), .RSEL_W(RSEL_W), .FRAC_W(FRAC_W)) bus ();

    baud_tick_gen #(
        .DIV_W(DIV_W), .OVERSAMPLE(OS), .RSEL_W(RSEL_W), .FRAC_W(FRAC_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model: mode 0 idle, 1 load, 2 run; ticks scheduled by absolute time since LOAD.
    int m_mode = 0;
    int m_t = 0;
    int m_next_rx = 0;
    int m_rx_cnt = 0;
    int m_d = 1;
    int m_frac = 0;
    int m_divq = 0;
    int m_fracq = 0;

    int cyc = 0;
    int last_rx = 0;
    int rx_gap = 0;
    int prev_rx_gap = 0;
    int last_tx = 0;
    int tx_gap = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int div_eff_model();
        int d;
        d = bus.div_ovr ? int'(bus.div_value) : TBL[bus.rate_sel];
        return (d == 0) ? 1 : d;
    endfunction

    function automatic int frac_eff_model();
`ifdef BAUD_FRAC_EN
        return bus.div_ovr ? int'(bus.div_frac) : 0;
`else
        return 0;
`endif
    endfunction

    // Extra cycle on reload k when k*frac crosses a multiple of 2**FRAC_W.
    function automatic int carry_at(input int k, input int f);
        return ((k * f) >> FRAC_W) - (((k - 1) * f) >> FRAC_W);
    endfunction

    task automatic run_cycle();
        logic exp_rx;
        logic exp_tx;
        logic exp_lock;
        int   deff;
        int   feff;
        @(negedge clk);
        exp_lock = (m_mode == 2);
        exp_rx   = exp_lock && (m_t == m_next_rx);
        exp_tx   = exp_rx && (((m_rx_cnt + 1) % OS) == 0);
        check_val("rx_tick", 32'(bus.rx_tick), 32'(exp_rx));
        check_val("tx_tick", 32'(bus.tx_tick), 32'(exp_tx));
        check_val("locked", 32'(bus.locked), 32'(exp_lock));
        if (bus.rx_tick === 1'b1) begin
            prev_rx_gap = rx_gap;
            rx_gap      = cyc - last_rx;
            last_rx     = cyc;
        end
        if (bus.tx_tick === 1'b1) begin
            tx_gap  = cyc - last_tx;
            last_tx = cyc;
        end
        deff = div_eff_model();
        feff = frac_eff_model();
        @(posedge clk);
        if (exp_rx) begin
            m_rx_cnt++;
            m_next_rx += m_d + carry_at(m_rx_cnt, m_frac);
        end
        m_t++;
        if (rst) begin
            m_mode = 0;
        end else begin
            case (m_mode)
                0: if (bus.en) begin m_mode = 1; m_t = 0; end
                1: begin
                    if (bus.en) begin
                        m_mode    = 2;
                        m_d       = deff;
                        m_frac    = feff;
                        m_next_rx = deff;
                        m_rx_cnt  = 0;
                    end else begin
                        m_mode = 0;
                    end
                end
                default: begin
                    if (!bus.en) m_mode = 0;
                    else if (deff != m_divq || feff != m_fracq) begin m_mode = 1; m_t = 0; end
                end
            endcase
        end
        m_divq  = deff;
        m_fracq = feff;
        cyc++;
        #1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.rate_sel  = '0;
        bus.div_ovr   = 1'b1;
        bus.div_value = 16'd4;
        bus.div_frac  = '0;
        @(posedge clk);
        #1;
        run_cycle();
        rst = 1'b0;
        run_cycles(2);
        check_val("reset_rx", 32'(bus.rx_tick), 32'd0);
        check_val("reset_locked", 32'(bus.locked), 32'd0);

        $display("[TB] override divisor 4");
        bus.en = 1'b1;
        run_cycles(140);
        check_val("gap_rx_div4", 32'(rx_gap), 32'd4);
        check_val("gap_tx_div4", 32'(tx_gap), 32'd64);

        $display("[TB] table rate 9600");
        bus.div_ovr  = 1'b0;
        bus.rate_sel = 2'd3;
        run_cycles(11000);
        check_val("gap_rx_tbl3", 32'(rx_gap), 32'd326);
        check_val("gap_tx_tbl3", 32'(tx_gap), 32'd5216);

        $display("[TB] divisor change mid-period");
        bus.div_ovr   = 1'b1;
        bus.div_value = 16'd4;
        run_cycles(30);
        bus.div_value = 16'd6;
        run_cycles(100);
        check_val("gap_rx_div6", 32'(rx_gap), 32'd6);

        $display("[TB] divisor 0 and 1");
        bus.div_value = 16'd0;
        run_cycles(40);
        check_val("gap_rx_div0", 32'(rx_gap), 32'd1);
        check_val("gap_tx_div0", 32'(tx_gap), 32'd16);
        bus.div_value = 16'd1;
        run_cycles(40);
        check_val("gap_rx_div1", 32'(rx_gap), 32'd1);
        check_val("gap_tx_div1", 32'(tx_gap), 32'd16);

        $display("[TB] reset and disable mid-period");
        bus.div_value = 16'd4;
        run_cycles(9);
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        run_cycles(30);
        check_val("gap_rx_after_rst", 32'(rx_gap), 32'd4);
        run_cycles(7);
        bus.en = 1'b0;
        run_cycles(5);
        bus.en = 1'b1;
        run_cycles(30);
        check_val("gap_rx_after_en", 32'(rx_gap), 32'd4);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) bus.en = ~bus.en;
            if ($urandom_range(0, 29) == 0) bus.div_value = 16'($urandom_range(0, 9));
            if ($urandom_range(0, 29) == 0) bus.div_frac = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 199) == 0);
            run_cycle();
        end
        rst          = 1'b0;
        bus.div_frac = '0;

`ifdef BAUD_FRAC_EN
        $display("[TB] fractional divisor 4.5");
        bus.en        = 1'b1;
        bus.div_value = 16'd4;
        bus.div_frac  = 4'd8;
        run_cycles(300);
        check_val("gap_pair_frac", 32'(rx_gap + prev_rx_gap), 32'd9);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
- Parametrised successor to the fixed-tap baud clock divider; generates single-cycle clock-enable ticks rather than derived clocks.
- rx_tick is the receiver oversample enable; tx_tick is the 1x bit enable.
- Divisor comes from a selectable rate table or a runtime override.
- Sits between the system clock and the UART TX/RX engines; all logic runs on clk.

Parameters:
- DIV_W, 16, width of the prescaler divisor (clk cycles per rx_tick).
- OVERSAMPLE, 16, rx_ticks per tx_tick; legal range 2..256.
- RSEL_W, 2, width of rate_sel; table has 2**RSEL_W entries.
- FRAC_W, 4, fractional divisor bits (used only with BAUD_FRAC_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  run enable; low holds the counters idle.
- rate_sel  in  RSEL_W  index into the baud_pkg rate table.
- div_ovr  in  1  1 = use div_value instead of the table.
- div_value  in  DIV_W  override divisor, integer part.
- div_frac  in  FRAC_W  override fractional part; ignored without BAUD_FRAC_EN.
- rx_tick  out  1  one-cycle pulse every divisor clk cycles.
- tx_tick  out  1  one-cycle pulse every OVERSAMPLE rx_ticks, coincident with an rx_tick.
- locked  out  1  high while in RUN with a stable divisor.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: rx_tick=0, tx_tick=0, locked=0, state=IDLE, prescaler=0, os_cnt=0.
- Effective divisor: div_eff = div_ovr ? div_value : RATE_TBL[rate_sel]. A div_eff of 0 is treated as 1.
- div_eff is registered every cycle as div_q. A change is flagged when div_eff != div_q.
- FSM states: IDLE, LOAD, RUN.
  - IDLE: outputs 0. If en=1, go to LOAD.
  - LOAD: one cycle. prescaler <= div_eff-1, os_cnt <= OVERSAMPLE-1, locked=0. Go to RUN (or IDLE if en=0).
  - RUN: locked=1.
    - prescaler decrements each cycle.
    - At prescaler==0: rx_tick=1 on that cycle, prescaler reloads div_q-1.
    - On each rx_tick, os_cnt decrements. tx_tick=1 when rx_tick and os_cnt==0; os_cnt then reloads OVERSAMPLE-1.
- Latency: first rx_tick occurs div_eff cycles after LOAD; first tx_tick occurs div_eff*OVERSAMPLE cycles after LOAD.
- Divisor change in RUN: go to LOAD the next cycle. No tick is emitted on the LOAD cycle, and the phase restarts cleanly.
- en falling in RUN: go to IDLE next cycle. A tick due on that same cycle still fires.
- Divisor change and en=0 together: IDLE takes priority.
- rst mid-operation: all outputs go to reset values on the next edge; no partial tick.
- div_eff=1: rx_tick is continuously high in RUN. tx_tick pulses every OVERSAMPLE cycles.
- Counters wrap only via reload; no underflow past 0.

Optional Feature:
- Macro: BAUD_FRAC_EN.
- Defined:
  - An FRAC_W-bit accumulator adds div_frac on each rx_tick reload.
  - On carry-out, that reload uses div_q (one extra cycle). Average period = div_value + div_frac/2**FRAC_W.
  - The accumulator clears in LOAD and on reset. Table entries keep frac=0.
- Undefined: integer divisor only; div_frac is ignored and no accumulator exists.

Decomposition:
- Package baud_pkg holds:
  - RATE_TBL: divisors for 1200/2400/4800/9600 baud at 50 MHz with 16x oversample = 2604/1302/651/326.
  - The state enum (IDLE/LOAD/RUN).
  - Default widths.
- One sub-module, baud_prescaler: a loadable down-counter with a terminal-count pulse and the optional fractional accumulator. It is instantiated once for the prescaler; os_cnt is an inline counter.

Test Plan:
- Reset, then en=1, div_ovr=1, div_value=4, OVERSAMPLE=16 -> locked high 1 cycle after LOAD; rx_tick every 4 cycles; tx_tick every 64 cycles, coincident with rx_tick.
- rate_sel=3, div_ovr=0 -> rx_tick period 326 cycles; tx_tick period 5216 cycles.
- In RUN, change div_value 4->6 mid-period -> locked drops for 1 cycle (LOAD); next rx_tick 6 cycles after LOAD; os_cnt restarts.
- div_value=0 and then 1 -> rx_tick held high every RUN cycle; tx_tick every 16 cycles.
- Assert rst or drop en mid-period -> all outputs 0 next cycle; re-enable gives first rx_tick exactly div_eff cycles after LOAD.
- BAUD_FRAC_EN, div_value=4, div_frac=8, FRAC_W=4 -> rx_tick spacing alternates 4,5; average over 32 ticks = 4.5 cycles.
